// File: rtl/spi_responder_pkg.sv
// Shared definitions for the SPI responder: FSM states and byte protocol constants.
package spi_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMD   = 2'd1,
    S_WDATA = 2'd2,
    S_RDATA = 2'd3
  } state_t;

  localparam int CMD_RW_BIT = 7;
  localparam int BYTE_BITS  = 8;

endpackage

// File: rtl/spi_resp_sync.sv
// SYNC-deep synchronizer with single-cycle rise/fall pulses on the synchronized level.
module spi_resp_sync
  import spi_responder_pkg::*;
#(
  parameter int   SYNC    = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC-1:0] r_sync;
  logic            r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= RST_VAL ? '1 : '0;
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC-2:0], i_d};
      r_prev <= r_sync[SYNC-1];
    end
  end

  assign o_q    = r_sync[SYNC-1];
  assign o_rise =  o_q & ~r_prev;
  assign o_fall = ~o_q &  r_prev;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 target bridging an external master onto a simple register bus.
// Optional SPI_RESP_STATUS_EN: shift status_in out on miso during the command byte.
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int AW   = 7,
  parameter int SYNC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ssb,
  input  logic          sck,
  input  logic          mosi,
  output logic          miso,
  output logic          miso_oe,
  output logic [AW-1:0] addr,
  output logic [7:0]    wdata,
  output logic          we,
  output logic          re,
  input  logic [7:0]    rdata,
  input  logic [7:0]    status_in,
  output logic          busy
);

  logic w_sck_s, w_sck_rise, w_sck_fall;
  logic w_ssb_s, w_ssb_rise, w_ssb_fall;
  logic w_mosi_s, w_unused_mosi_rise, w_unused_mosi_fall;
  logic w_byte_done;
  logic [7:0] w_rx_byte;

  state_t        r_state;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_rxsh;
  logic [7:0]    r_txsh;
  logic          r_miso, r_oe, r_busy, r_armed;
  logic          r_we, r_re, r_ld;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_wdata;

  // Synchronizers reset low so a reset taken mid-frame never produces a spurious ssb fall.
  spi_resp_sync #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .reset(reset), .i_d(sck),
    .o_q(w_sck_s), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );
  spi_resp_sync #(.SYNC(SYNC), .RST_VAL(1'b0)) u_ssb_sync (
    .clk(clk), .reset(reset), .i_d(ssb),
    .o_q(w_ssb_s), .o_rise(w_ssb_rise), .o_fall(w_ssb_fall)
  );
  spi_resp_sync #(.SYNC(SYNC), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .reset(reset), .i_d(mosi),
    .o_q(w_mosi_s), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
  );

`ifndef SPI_RESP_STATUS_EN
  logic w_unused_status;
  assign w_unused_status = ^status_in;
`endif

  assign w_rx_byte   = {r_rxsh[6:0], w_mosi_s};
  assign w_byte_done = w_sck_rise && (r_bitcnt == 3'(BYTE_BITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_bitcnt <= '0;
      r_rxsh   <= '0;
      r_txsh   <= '0;
      r_miso   <= 1'b0;
      r_oe     <= 1'b0;
      r_busy   <= 1'b0;
      r_armed  <= 1'b0;
      r_we     <= 1'b0;
      r_re     <= 1'b0;
      r_ld     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_we  <= 1'b0;
      r_re  <= 1'b0;
      r_ld  <= r_re;
      // Select only counts once ssb has been seen high since reset.
      r_busy <= ~w_ssb_s & r_armed;
      r_oe   <= ~w_ssb_s & r_armed;
      if (w_ssb_s) r_armed <= 1'b1;
      if (r_we || r_re) r_addr <= r_addr + AW'(1);
      if (r_ld) r_txsh <= rdata;
      if (w_sck_rise && r_state != S_IDLE) begin
        r_rxsh   <= w_rx_byte;
        r_bitcnt <= r_bitcnt + 3'd1;
      end

      case (r_state)
        S_IDLE: begin
          r_miso   <= 1'b0;
          r_bitcnt <= '0;
          if (w_ssb_fall && !w_sck_s) begin
            r_state <= S_CMD;
`ifdef SPI_RESP_STATUS_EN
            r_miso  <= status_in[7];
            r_txsh  <= {status_in[6:0], 1'b0};
`endif
          end
        end
        S_CMD: begin
`ifdef SPI_RESP_STATUS_EN
          if (w_sck_fall) begin
            r_miso <= r_txsh[7];
            r_txsh <= {r_txsh[6:0], 1'b0};
          end
`else
          r_miso <= 1'b0;
`endif
          if (w_byte_done) begin
            r_addr <= w_rx_byte[AW-1:0];
            if (w_rx_byte[CMD_RW_BIT]) begin
              r_state <= S_RDATA;
              r_re    <= 1'b1;
            end else begin
              r_state <= S_WDATA;
            end
          end
        end
        S_WDATA: begin
          r_miso <= 1'b0;
          if (w_byte_done) begin
            r_wdata <= w_rx_byte;
            r_we    <= 1'b1;
          end
        end
        S_RDATA: begin
          if (w_sck_fall) begin
            r_miso <= r_txsh[7];
            r_txsh <= {r_txsh[6:0], 1'b0};
          end
          if (w_byte_done) r_re <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase

      // Placed last so a byte completing in the same cycle still issues its strobe.
      if (w_ssb_rise) begin
        r_state  <= S_IDLE;
        r_bitcnt <= '0;
        r_miso   <= 1'b0;
      end
    end
  end

  assign miso    = r_miso;
  assign miso_oe = r_oe;
  assign busy    = r_busy;
  assign addr    = r_addr;
  assign wdata   = r_wdata;
  assign we      = r_we;
  assign re      = r_re;

endmodule

// File: tb/tb_spi_responder.sv
// Directed and random SPI frames against a frame-level model of the register protocol.
module tb_spi_responder;

  logic       clk = 1'b0;
  logic       reset, ssb, sck, mosi;
  logic       miso, miso_oe, we, re, busy;
  logic [6:0] addr;
  logic [7:0] wdata, status_in;
  logic [7:0] rdata = 8'h00;

  int n_chk  = 0;
  int n_pass = 0;

  logic [14:0] wq[$];
  logic [6:0]  rq[$];

  logic [7:0] fb  [16];
  logic [7:0] rxb [16];
  int         fn, fpart;
  logic [7:0] rdummy;

  always #20 clk = ~clk;

  spi_responder #(.AW(7), .SYNC(2)) dut (
    .clk(clk), .reset(reset), .ssb(ssb), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .addr(addr), .wdata(wdata),
    .we(we), .re(re), .rdata(rdata), .status_in(status_in), .busy(busy)
  );

  // Register client: logs strobes, returns addr^0x3C the cycle after re.
  always @(posedge clk) begin
    if (we) wq.push_back({addr, wdata});
    if (re) begin
      rq.push_back(addr);
      rdata <= {1'b0, addr} ^ 8'h3C;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      repeat (4) @(negedge clk);
      rx = {rx[6:0], miso};
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  // Expected effects of one frame, from the byte-level protocol rules.
  task automatic check_frame(input string tag);
    int   a, nw, nr, ea;
    logic rd;
    logic [7:0] em;
    a  = int'(fb[0][6:0]);
    rd = fb[0][7];
    nw = (fn > 0 && !rd) ? fn - 1 : 0;
    nr = (fn > 0 &&  rd) ? fn : 0;
    chk($sformatf("%s.wcnt", tag), wq.size(), nw);
    for (int i = 0; i < nw && i < wq.size(); i++) begin
      ea = (a + i) % 128;
      chk($sformatf("%s.waddr%0d", tag, i), wq[i][14:8], ea);
      chk($sformatf("%s.wdata%0d", tag, i), wq[i][7:0], fb[i+1]);
    end
    chk($sformatf("%s.rcnt", tag), rq.size(), nr);
    for (int i = 0; i < nr && i < rq.size(); i++)
      chk($sformatf("%s.raddr%0d", tag, i), rq[i], (a + i) % 128);
    for (int i = 0; i < fn; i++) begin
      em = 8'h00;
      if (i == 0) begin
`ifdef SPI_RESP_STATUS_EN
        em = status_in;
`endif
      end else if (rd) begin
        em = 8'(((a + i - 1) % 128) ^ 'h3C);
      end
      chk($sformatf("%s.miso%0d", tag, i), rxb[i], em);
    end
  endtask

  task automatic run_frame(input string tag);
    wq.delete();
    rq.delete();
    ssb = 1'b0;
    repeat (4) @(negedge clk);
    chk($sformatf("%s.busy", tag), busy, 1'b1);
    chk($sformatf("%s.oe", tag), miso_oe, 1'b1);
    for (int i = 0; i < fn; i++) spi_xfer(fb[i], 8, rxb[i]);
    if (fpart > 0) spi_xfer(fb[fn], fpart, rdummy);
    repeat (4) @(negedge clk);
    ssb = 1'b1;
    repeat (8) @(negedge clk);
    chk($sformatf("%s.idle", tag), {busy, miso_oe, miso}, 3'b000);
    check_frame(tag);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk($sformatf("%s.miso", tag), miso, 1'b0);
    chk($sformatf("%s.oe", tag), miso_oe, 1'b0);
    chk($sformatf("%s.we_re", tag), {we, re}, 2'b00);
    chk($sformatf("%s.busy", tag), busy, 1'b0);
    chk($sformatf("%s.addr", tag), addr, 7'h00);
    chk($sformatf("%s.wdata", tag), wdata, 8'h00);
  endtask

  initial begin
    reset = 1'b1; ssb = 1'b1; sck = 1'b0; mosi = 1'b0; status_in = 8'h00;
    fpart = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    repeat (10) @(negedge clk);

    fb[0] = 8'h05; fb[1] = 8'hAA; fb[2] = 8'h55; fn = 3;
    run_frame("wburst");
    fb[0] = 8'h85; fb[1] = 8'h00; fb[2] = 8'h00; fn = 3;
    run_frame("rburst");
    fb[0] = 8'h7F; fb[1] = 8'h11; fb[2] = 8'h22; fn = 3;
    run_frame("wrap");
    fb[0] = 8'hFF; fb[1] = 8'h00; fb[2] = 8'h00; fn = 3;
    run_frame("rwrap");
    status_in = 8'hC3;
    fb[0] = 8'h80; fn = 1;
    run_frame("status");
    status_in = 8'h00;
    fb[0] = 8'h03; fb[1] = 8'hF0; fn = 1; fpart = 4;
    run_frame("abort");
    fpart = 0;
    fb[0] = 8'h04; fb[1] = 8'h99; fn = 2;
    run_frame("after_abort");

    // ssb falls while sck is high: whole frame must be ignored.
    wq.delete(); rq.delete();
    sck = 1'b1;
    repeat (4) @(negedge clk);
    ssb = 1'b0;
    repeat (4) @(negedge clk);
    sck = 1'b0;
    repeat (4) @(negedge clk);
    spi_xfer(8'h05, 8, rdummy);
    spi_xfer(8'h77, 8, rdummy);
    spi_xfer(8'h88, 8, rdummy);
    repeat (4) @(negedge clk);
    ssb = 1'b1;
    repeat (8) @(negedge clk);
    chk("proterr.strobes", wq.size() + rq.size(), 0);

    // Reset in the middle of a read-data byte.
    ssb = 1'b0;
    repeat (4) @(negedge clk);
    spi_xfer(8'h85, 8, rdummy);
    spi_xfer(8'h00, 3, rdummy);
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wq.delete(); rq.delete();
    spi_xfer(8'h00, 5, rdummy);
    spi_xfer(8'h12, 8, rdummy);
    chk("midrst.busy_after", busy, 1'b0);
    repeat (4) @(negedge clk);
    ssb = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst.strobes", wq.size() + rq.size(), 0);
    chk("midrst.addr", addr, 7'h00);

    for (int k = 0; k < 24; k++) begin
      fn = $urandom_range(1, 6);
      for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
      fpart = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      status_in = 8'($urandom);
      run_frame($sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
